// File: rtl/mem_access_pkg.sv
// Shared types and constants for the data-memory access stage and its address handler.
package mem_access_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    localparam int unsigned CNT_WIDTH           = 4;
    localparam int unsigned DEFAULT_WAIT_STATES = 1;

    // Stack regions in word addresses; the user stack sits directly below the kernel stack.
    localparam int unsigned KSTACK_TOP    = 4096;
    localparam int unsigned KSTACK_BOTTOM = 6143;
    localparam int unsigned USTACK_TOP    = 0;
    localparam int unsigned USTACK_BOTTOM = KSTACK_TOP - 1;

endpackage

// File: rtl/wait_state_counter.sv
// Loadable 4-bit down-counter; counts RAM wait states and flags when it reaches zero.
module wait_state_counter
    import mem_access_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic [CNT_WIDTH-1:0] i_load_val,
    input  logic                 i_dec,
    output logic                 o_zero_c
);

    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_WIDTH'(1);
        end
    end

    assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/data_memory_access_unit.sv
// Multi-cycle data-memory access stage driving a single-port synchronous RAM.
// Optional feature: define KERNEL_PROTECT_EN to fault user-mode accesses to the kernel stack.
module data_memory_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned WORD_SIZE           = 32,
    parameter int unsigned ADDR_WIDTH          = 13,
    parameter int unsigned WAIT_STATES         = DEFAULT_WAIT_STATES,
    parameter int unsigned KERNEL_STACK_TOP    = KSTACK_TOP,
    parameter int unsigned KERNEL_STACK_BOTTOM = KSTACK_BOTTOM
)(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [WORD_SIZE-1:0]  req_address,
    input  logic [WORD_SIZE-1:0]  req_wdata,
    input  logic                  is_kernel,
    output logic                  stall,
    output logic                  resp_valid,
    output logic                  resp_fault,
    output logic [WORD_SIZE-1:0]  resp_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    input  logic [WORD_SIZE-1:0]  mem_rdata
);

`ifdef KERNEL_PROTECT_EN
    localparam bit PROTECT_EN = 1'b1;
`else
    localparam bit PROTECT_EN = 1'b0;
`endif

    state_t                r_state, w_state_next;
    logic                  r_write, w_write_next;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
    logic [WORD_SIZE-1:0]  r_wdata, w_wdata_next;
    logic                  r_kernel, w_kernel_next;
    logic                  r_fault, w_fault_next;
    logic                  r_mem_en, r_mem_we;
    logic                  r_resp_valid, r_resp_fault, r_req_ready;
    logic [WORD_SIZE-1:0]  r_resp_rdata;
    logic                  w_cnt_load, w_cnt_dec, w_cnt_zero;
    logic                  w_range_fault, w_kstack_hit, w_req_fault;

    // Fault check on the incoming request, evaluated in the acceptance cycle.
    assign w_range_fault = |req_address[WORD_SIZE-1:ADDR_WIDTH];
    assign w_kstack_hit  = !is_kernel
                        && (req_address >= WORD_SIZE'(KERNEL_STACK_TOP))
                        && (req_address <= WORD_SIZE'(KERNEL_STACK_BOTTOM));
    assign w_req_fault   = w_range_fault | (PROTECT_EN & w_kstack_hit);

    wait_state_counter u_wait_cnt (
        .clk        (clock),
        .rst_n      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (CNT_WIDTH'(WAIT_STATES - 1)),
        .i_dec      (w_cnt_dec),
        .o_zero_c   (w_cnt_zero)
    );

    always_comb begin
        w_state_next  = r_state;
        w_write_next  = r_write;
        w_addr_next   = r_addr;
        w_wdata_next  = r_wdata;
        w_kernel_next = r_kernel;
        w_fault_next  = r_fault;
        w_cnt_load    = 1'b0;
        w_cnt_dec     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_write_next  = req_write;
                    w_addr_next   = req_address[ADDR_WIDTH-1:0];
                    w_wdata_next  = req_wdata;
                    w_kernel_next = is_kernel;
                    w_fault_next  = w_req_fault;
                    w_state_next  = w_req_fault ? S_RESPOND : S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_cnt_load   = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_cnt_zero) begin
                    w_state_next = S_RESPOND;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            S_RESPOND: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so each is valid for the whole state cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_kernel     <= 1'b0;
            r_fault      <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_rdata <= '0;
            r_req_ready  <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_write      <= w_write_next;
            r_addr       <= w_addr_next;
            r_wdata      <= w_wdata_next;
            r_kernel     <= w_kernel_next;
            r_fault      <= w_fault_next;
            r_mem_en     <= (w_state_next == S_ACCESS);
            r_mem_we     <= (w_state_next == S_ACCESS) && w_write_next;
            r_resp_valid <= (w_state_next == S_RESPOND);
            r_resp_fault <= (w_state_next == S_RESPOND) && w_fault_next;
            r_req_ready  <= (w_state_next == S_IDLE);
            if (w_state_next == S_RESPOND) begin
                r_resp_rdata <= (w_write_next || w_fault_next) ? '0 : mem_rdata;
            end
        end
    end

    assign stall      = (r_state != S_IDLE) || req_valid;
    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_fault = r_resp_fault;
    assign resp_rdata = r_resp_rdata;
    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;

endmodule

// File: tb/tb_data_memory_access_unit.sv
// Bench for data_memory_access_unit: two instances (1 and 4 wait states) against a word-array model.
module tb_data_memory_access_unit;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        req_valid [2];
    logic        req_write [2];
    logic [31:0] req_address [2];
    logic [31:0] req_wdata [2];
    logic        is_kernel [2];

    logic        rdy0, stall0, rv0, rf0, en0, we0;
    logic        rdy1, stall1, rv1, rf1, en1, we1;
    logic [31:0] rd0, wd0, mrd0, rd1, wd1, mrd1;
    logic [12:0] ad0, ad1;

    bit [31:0] ram0 [8192];
    bit [31:0] ram1 [8192];
    bit [31:0] model [2][8192];

    int checks = 0;
    int errors = 0;

    data_memory_access_unit #(.WORD_SIZE(32), .ADDR_WIDTH(13), .WAIT_STATES(1),
                              .KERNEL_STACK_TOP(4096), .KERNEL_STACK_BOTTOM(6143)) u_dut0 (
        .clock(clock), .reset(reset), .req_valid(req_valid[0]), .req_ready(rdy0),
        .req_write(req_write[0]), .req_address(req_address[0]), .req_wdata(req_wdata[0]),
        .is_kernel(is_kernel[0]), .stall(stall0), .resp_valid(rv0), .resp_fault(rf0),
        .resp_rdata(rd0), .mem_en(en0), .mem_we(we0), .mem_addr(ad0), .mem_wdata(wd0),
        .mem_rdata(mrd0));

    data_memory_access_unit #(.WORD_SIZE(32), .ADDR_WIDTH(13), .WAIT_STATES(4),
                              .KERNEL_STACK_TOP(4096), .KERNEL_STACK_BOTTOM(6143)) u_dut1 (
        .clock(clock), .reset(reset), .req_valid(req_valid[1]), .req_ready(rdy1),
        .req_write(req_write[1]), .req_address(req_address[1]), .req_wdata(req_wdata[1]),
        .is_kernel(is_kernel[1]), .stall(stall1), .resp_valid(rv1), .resp_fault(rf1),
        .resp_rdata(rd1), .mem_en(en1), .mem_we(we1), .mem_addr(ad1), .mem_wdata(wd1),
        .mem_rdata(mrd1));

    // Synchronous single-port RAMs: read data appears the cycle after the enable.
    always @(posedge clock) begin
        if (en0) begin
            if (we0) ram0[ad0] <= wd0;
            else     mrd0 <= ram0[ad0];
        end
    end
    always @(posedge clock) begin
        if (en1) begin
            if (we1) ram1[ad1] <= wd1;
            else     mrd1 <= ram1[ad1];
        end
    end

    typedef struct {
        logic        rdy, stall, rv, rf, en, we;
        logic [31:0] rd, wd;
        logic [12:0] ad;
    } obs_t;

    function automatic obs_t get(input int d);
        obs_t o;
        if (d == 0) begin
            o.rdy = rdy0; o.stall = stall0; o.rv = rv0; o.rf = rf0; o.en = en0; o.we = we0;
            o.rd = rd0; o.wd = wd0; o.ad = ad0;
        end else begin
            o.rdy = rdy1; o.stall = stall1; o.rv = rv1; o.rf = rf1; o.en = en1; o.we = we1;
            o.rd = rd1; o.wd = wd1; o.ad = ad1;
        end
        return o;
    endfunction

    function automatic int wait_states(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    // Reference fault rule: out of the 8K-word RAM, or a user access into the kernel stack.
    function automatic bit model_fault(input logic [31:0] a, input bit k);
        bit f;
        f = (a >= 32'd8192);
`ifdef KERNEL_PROTECT_EN
        if (!k && a >= 32'd4096 && a <= 32'd6143) f = 1'b1;
`else
        if (k && 1'b0) f = 1'b1;
`endif
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input int d, input string tag);
        obs_t o;
        o = get(d);
        chk({tag, "_ready"}, 32'(o.rdy), 32'd1);
        chk({tag, "_stall"}, 32'(o.stall), 32'd0);
        chk({tag, "_rvalid"}, 32'(o.rv), 32'd0);
        chk({tag, "_rfault"}, 32'(o.rf), 32'd0);
        chk({tag, "_mem_en"}, 32'(o.en), 32'd0);
        chk({tag, "_mem_we"}, 32'(o.we), 32'd0);
        chk({tag, "_rdata"}, o.rd, 32'd0);
    endtask

    // One request/response transaction; toggle wiggles req_valid while the access is in flight.
    task automatic xact(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input bit k, input bit toggle);
        bit          flt, seen;
        int          lat, exp_lat, en_n, we_n;
        logic [31:0] exp_rd;
        obs_t        o;
        flt     = model_fault(a, k);
        exp_lat = flt ? 1 : wait_states(d) + 2;
        exp_rd  = (wr || flt) ? 32'd0 : model[d][a[12:0]];
        @(negedge clock);
        req_valid[d] = 1'b1; req_write[d] = wr; req_address[d] = a;
        req_wdata[d] = wd;   is_kernel[d] = k;
        #1;
        o = get(d);
        chk("accept_ready", 32'(o.rdy), 32'd1);
        chk("accept_stall", 32'(o.stall), 32'd1);
        seen = 1'b0; lat = 99; en_n = 0; we_n = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clock);
            o = get(d);
            if (o.en) begin
                en_n++;
                chk("mem_addr", 32'(o.ad), 32'(a[12:0]));
                if (o.we) begin
                    we_n++;
                    chk("mem_wdata", o.wd, wd);
                end
            end
            chk("busy_stall", 32'(o.stall), 32'd1);
            if (o.rv) begin
                seen = 1'b1;
                lat  = c;
                chk("resp_fault", 32'(o.rf), 32'(flt));
                chk("resp_rdata", o.rd, exp_rd);
                req_valid[d] = 1'b0;
            end else if (toggle) begin
                req_valid[d] = 1'($urandom);
            end
        end
        req_valid[d] = 1'b0;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("mem_en_cycles", 32'(en_n), flt ? 32'd0 : 32'd1);
        chk("mem_we_cycles", 32'(we_n), (wr && !flt) ? 32'd1 : 32'd0);
        if (wr && !flt) model[d][a[12:0]] = wd;
        @(negedge clock);
        o = get(d);
        chk("idle_ready", 32'(o.rdy), 32'd1);
        chk("idle_stall", 32'(o.stall), 32'd0);
        chk("idle_rvalid", 32'(o.rv), 32'd0);
        chk("hold_rdata", o.rd, exp_rd);
    endtask

    initial begin
        int          acc [$];
        int          idx;
        logic [31:0] ba [4];
        obs_t        o;

        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0; req_address[i] = '0;
            req_wdata[i] = '0;   is_kernel[i] = 1'b0;
        end
        repeat (2) @(negedge clock);
        chk_reset_state(0, "rst0");
        chk_reset_state(1, "rst1");
        reset = 1'b1;

        // Directed: store then load, out-of-range, kernel-stack privilege.
        xact(0, 1'b1, 32'd100, 32'hDEADBEEF, 1'b1, 1'b0);
        xact(0, 1'b0, 32'd100, 32'd0, 1'b1, 1'b0);
        xact(0, 1'b0, 32'h0000_2000, 32'd0, 1'b1, 1'b0);
        xact(0, 1'b1, 32'hFFFF_0010, 32'h1234_5678, 1'b1, 1'b0);
        xact(0, 1'b1, 32'd5000, 32'hCAFE_F00D, 1'b1, 1'b0);
        xact(0, 1'b0, 32'd5000, 32'd0, 1'b0, 1'b0);
        xact(0, 1'b0, 32'd5000, 32'd0, 1'b1, 1'b0);
        xact(0, 1'b0, 32'd8191, 32'd0, 1'b1, 1'b0);

        // Four wait states, with req_valid wiggling during the access.
        xact(1, 1'b1, 32'd100, 32'hA5A5_0F0F, 1'b1, 1'b1);
        xact(1, 1'b0, 32'd100, 32'd0, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a load's wait states.
        @(negedge clock);
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_address[1] = 32'd100; is_kernel[1] = 1'b1;
        repeat (2) @(negedge clock);
        #2;
        reset = 1'b0;
        req_valid[1] = 1'b0;
        #1;
        chk_reset_state(1, "midrst");
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            o = get(1);
            chk("midrst_no_resp", 32'(o.rv), 32'd0);
        end
        reset = 1'b1;
        xact(1, 1'b0, 32'd100, 32'd0, 1'b1, 1'b0);

        // Back-to-back loads with req_valid held: acceptances every WAIT_STATES+3 cycles.
        for (int i = 0; i < 4; i++) begin
            ba[i] = 32'($urandom_range(0, 63));
            xact(0, 1'b1, ba[i], $urandom, 1'b1, 1'b0);
        end
        @(negedge clock);
        idx = 0;
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_address[0] = ba[0]; is_kernel[0] = 1'b1;
        for (int c = 0; c < 60 && idx < 4; c++) begin
            o = get(0);
            if (o.rdy) acc.push_back(c);
            if (o.rv) begin
                chk("b2b_rdata", o.rd, model[0][ba[idx][12:0]]);
                idx++;
                if (idx < 4) req_address[0] = ba[idx];
                else         req_valid[0] = 1'b0;
            end
            @(negedge clock);
        end
        req_valid[0] = 1'b0;
        chk("b2b_count", 32'(acc.size()), 32'd4);
        for (int i = 1; i < acc.size(); i++) begin
            chk("b2b_gap", 32'(acc[i] - acc[i-1]), 32'd4);
        end

        // Randomized mix of loads/stores, privileges and address ranges on both instances.
        for (int n = 0; n < 30; n++) begin
            int          d, r;
            logic [31:0] a;
            d = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = $urandom | 32'h0000_2000;
            else if (r < 4)  a = 32'($urandom_range(4090, 6150));
            else             a = 32'($urandom_range(0, 31));
            xact(d, 1'($urandom), a, $urandom, 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_access_unit.md
# data_memory_access_unit

Multi-cycle data-memory access stage sitting directly downstream of the memory address handler: it consumes the resolved data address, store data, access direction and privilege mode, and drives a single-port synchronous RAM with configurable wait states. It returns load data, a one-cycle response pulse and a core stall signal, and flags faulting accesses instead of issuing them. Out-of-range requests fault; with protection compiled in, user-mode accesses to the kernel stack also fault.

## Interface
Parameters:
- WORD_SIZE, 32, data and address width of the core side
- ADDR_WIDTH, 13, RAM address width (8192 words)
- WAIT_STATES, 1, idle cycles between RAM enable and read-data capture; legal range 1..15
- KERNEL_STACK_TOP, 4096, lowest kernel-stack word address
- KERNEL_STACK_BOTTOM, 6143, highest kernel-stack word address

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  access request
- req_ready  out  1  unit can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_address  in  WORD_SIZE  word address
- req_wdata  in  WORD_SIZE  store data
- is_kernel  in  1  privilege mode of the request
- stall  out  1  hold the core pipeline
- resp_valid  out  1  one-cycle completion pulse
- resp_fault  out  1  qualifies resp_valid: access rejected
- resp_rdata  out  WORD_SIZE  load data, valid with resp_valid
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  WORD_SIZE  RAM write data
- mem_rdata  in  WORD_SIZE  RAM read data, valid the cycle after mem_en

## Operation
- States: IDLE, ACCESS, WAIT, RESPOND.
- IDLE: req_ready=1. On req_valid, latch req_write, req_address, req_wdata and is_kernel, then run the fault check:
  - no fault: go to ACCESS;
  - fault: go directly to RESPOND with the fault flag set and no RAM access.
- Fault condition: req_address[WORD_SIZE-1:ADDR_WIDTH] != 0.
- ACCESS (1 cycle): mem_en=1, mem_we=latched write, mem_addr=latched address[ADDR_WIDTH-1:0], mem_wdata=latched data. Then go to WAIT and load the counter with WAIT_STATES-1.
- WAIT: mem_en=0, mem_addr held. The counter decrements each cycle. At counter==0, loads capture mem_rdata into resp_rdata on that edge, then the state goes to RESPOND.
- RESPOND (1 cycle): resp_valid=1 and resp_fault=latched fault. resp_rdata holds the captured data for loads, 0 for stores and faults. Then go to IDLE.
- stall = (state != IDLE) or (state == IDLE and req_valid).
- req_valid while not IDLE is ignored. The requester holds the request until it sees resp_valid.
- resp_rdata holds its value until the next RESPOND.

## Timing
- Reset values: state IDLE, all outputs 0 except req_ready=1, counter 0, latched fields 0. Reset applies immediately (asynchronous).
- Reset mid-access: mem_en and mem_we drop immediately, any pending response is discarded, and no RAM write completes after reset asserts.
- Latency from the acceptance edge: ACCESS in cycle +1, WAIT in cycles +2..+1+WAIT_STATES, RESPOND in cycle +2+WAIT_STATES.
  - WAIT_STATES=1: resp_valid in cycle +3.
  - Fault: resp_valid in cycle +1.
- Throughput: one access per WAIT_STATES+3 cycles. The earliest next acceptance is the cycle after RESPOND.
- mem_en is high for exactly one cycle per non-faulting access.

## Configuration
- KERNEL_PROTECT_EN defined: an access latched with is_kernel=0 and KERNEL_STACK_TOP <= address <= KERNEL_STACK_BOTTOM also faults (no RAM access, resp_fault=1).
- Not defined: only the range fault exists, and is_kernel is latched but otherwise unused.

## Structure
- Shared package mem_access_pkg:
  - state encoding (IDLE=0, ACCESS=1, WAIT=2, RESPOND=3);
  - default WAIT_STATES;
  - KERNEL/USER stack bound constants shared with the address handler.
- One sub-module, wait_state_counter: 4-bit loadable down-counter with a zero flag.

## Test plan
- Store 0xDEADBEEF to 100, then load 100 with WAIT_STATES=1 -> one mem_en cycle with mem_we=1 for the store; load resp_valid in cycle +3 with resp_rdata=0xDEADBEEF and resp_fault=0.
- Load from 0x00002000 (ADDR_WIDTH=13) -> resp_valid in cycle +1 with resp_fault=1 and resp_rdata=0; mem_en never asserted.
- With KERNEL_PROTECT_EN, user load from 5000 -> fault, no mem_en; kernel load from 5000 -> normal access. Without the macro, user load from 5000 -> normal access.
- WAIT_STATES=4 load -> resp_valid in cycle +6; stall high from the request cycle through RESPOND; req_valid toggles during WAIT are ignored.
- Assert reset during WAIT of a load -> outputs return to reset values asynchronously, no resp_valid, and the next request after release completes normally.
- Back-to-back loads with req_valid held continuously -> acceptances exactly WAIT_STATES+3 cycles apart.
